// File: rtl/shared_reg_arbiter_if.sv
// Bus bundle for shared_reg_arbiter: per-requester request/write lanes plus the grant and
// shared-register outputs. The arbiter uses the slave modport and requesters use the master.
interface shared_reg_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = 8
);
  localparam int unsigned IdW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ-1:0]        wr_en;
  logic [NUM_REQ*DATA_W-1:0] wdata;
  logic [NUM_REQ-1:0]        gnt;
  logic [DATA_W-1:0]         q;
  logic                      q_valid;
  logic [IdW-1:0]            owner_id;
  logic                      busy;

  modport master (
    output req, wr_en, wdata,
    input  gnt, q, q_valid, owner_id, busy
  );

  modport slave (
    input  req, wr_en, wdata,
    output gnt, q, q_valid, owner_id, busy
  );
endinterface

// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter that shares one register among NUM_REQ requesters with bounded hold time.
// Optional macro SHARED_REG_ARB_PRIO0_EN gives requester 0 absolute priority.
module shared_reg_arbiter #(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic               clk,
  input  logic               reset,
  shared_reg_arbiter_if.slave bus
);

  localparam int unsigned IdW   = $clog2(NUM_REQ);
  localparam int unsigned HoldW = $clog2(MAX_HOLD + 1);

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [IdW-1:0]     owner_q, owner_d;
  logic [IdW-1:0]     ptr_q, ptr_d;
  logic [HoldW-1:0]   hold_q, hold_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic               valid_q, valid_d;

  logic               win_found;
  logic [IdW-1:0]     win_id;
  int unsigned        scan_idx;
  logic               competitor;
  logic               preempt;
  logic [IdW-1:0]     next_ptr;
  logic               wr_hit;

  // Winner search: first set request scanning upward from ptr with wrap-around.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    scan_idx  = 0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      scan_idx = (32'(ptr_q) + off) % NUM_REQ;
      if (!win_found && bus.req[scan_idx]) begin
        win_found = 1'b1;
        win_id    = IdW'(scan_idx);
      end
    end
`ifdef SHARED_REG_ARB_PRIO0_EN
    if (bus.req[0]) begin
      win_found = 1'b1;
      win_id    = '0;
    end
`endif
  end

  assign competitor = |(bus.req & ~gnt_q);
  assign next_ptr   = (owner_q == IdW'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;

`ifdef SHARED_REG_ARB_PRIO0_EN
  assign preempt = (hold_q == HoldW'(MAX_HOLD)) && competitor && (owner_q != '0);
`else
  assign preempt = (hold_q == HoldW'(MAX_HOLD)) && competitor;
`endif

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    unique case (state_q)
      StIdle: begin
        if (win_found) begin
          state_d = StGrant;
          gnt_d   = {{(NUM_REQ-1){1'b0}}, 1'b1} << win_id;
          owner_d = win_id;
          hold_d  = HoldW'(1);
        end
      end
      StGrant: begin
        // Release and preempt both pass through IDLE so ownership never moves directly.
        if (!bus.req[owner_q] || preempt) begin
          state_d = StIdle;
          gnt_d   = '0;
          owner_d = '0;
          ptr_d   = next_ptr;
          hold_d  = '0;
        end else if (hold_q != HoldW'(MAX_HOLD)) begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        gnt_d   = '0;
        owner_d = '0;
        hold_d  = '0;
      end
    endcase
  end

  // Only the registered owner can write, including in the cycle its request drops.
  assign wr_hit = (state_q == StGrant) && bus.wr_en[owner_q];

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (wr_hit) begin
      data_d  = bus.wdata[32'(owner_q)*DATA_W +: DATA_W];
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      gnt_q   <= '0;
      owner_q <= '0;
      ptr_q   <= '0;
      hold_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign bus.gnt      = gnt_q;
  assign bus.owner_id = owner_q;
  assign bus.busy     = (state_q == StGrant);
  assign bus.q        = data_q;
  assign bus.q_valid  = valid_q;

  a_gnt_onehot0: assert property (@(posedge clk) disable iff (reset) $onehot0(gnt_q));
  a_busy_gnt: assert property (@(posedge clk) disable iff (reset)
    (state_q == StGrant) == (gnt_q != '0));
  a_owner_gnt: assert property (@(posedge clk) disable iff (reset)
    (state_q == StGrant) |-> gnt_q[owner_q]);

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Directed self-checking bench for shared_reg_arbiter (NUM_REQ=4, DATA_W=8, MAX_HOLD=8).
// Expectations follow the SHARED_REG_ARB_PRIO0_EN setting the bench is compiled with.
module tb_shared_reg_arbiter;

  localparam int unsigned NumReq  = 4;
  localparam int unsigned DataW   = 8;
  localparam int unsigned MaxHold = 8;

`ifdef SHARED_REG_ARB_PRIO0_EN
  localparam int unsigned Holder = 1;  // requester 0 is never preempted in this build
`else
  localparam int unsigned Holder = 0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  shared_reg_arbiter_if #(.NUM_REQ(NumReq), .DATA_W(DataW)) bus ();

  shared_reg_arbiter #(
    .NUM_REQ (NumReq),
    .DATA_W  (DataW),
    .MAX_HOLD(MaxHold)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req   = '0;
    bus.wr_en = '0;
    bus.wdata = '0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    n_vec++; if (bus.gnt !== 4'b0000) begin n_err++; $display("FAIL reset_gnt: got %b want 0000", bus.gnt); end
    n_vec++; if (bus.q !== 8'h00) begin n_err++; $display("FAIL reset_q: got %h want 00", bus.q); end
    n_vec++; if (bus.q_valid !== 1'b0) begin n_err++; $display("FAIL reset_q_valid: got %b want 0", bus.q_valid); end
    n_vec++; if (bus.owner_id !== 2'd0) begin n_err++; $display("FAIL reset_owner: got %0d want 0", bus.owner_id); end
    n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    bus.wr_en = 4'b0001;
    bus.wdata[7:0] = 8'h77;
    tick();
    n_vec++; if (bus.busy !== 1'b0 || bus.q_valid !== 1'b0) begin
      n_err++; $display("FAIL idle_no_req: got busy=%b q_valid=%b want 0 0", bus.busy, bus.q_valid);
    end
  endtask

  task automatic test_reset_mid_grant();
    apply_reset();
    bus.req   = 4'b0010;
    bus.wr_en = 4'b0010;
    bus.wdata[15:8] = 8'hA5;
    repeat (3) tick();
    n_vec++; if (bus.q !== 8'hA5) begin n_err++; $display("FAIL midrst_q_before: got %h want a5", bus.q); end
    n_vec++; if (bus.q_valid !== 1'b1) begin n_err++; $display("FAIL midrst_valid_before: got %b want 1", bus.q_valid); end
    n_vec++; if (bus.gnt !== 4'b0010) begin n_err++; $display("FAIL midrst_gnt_before: got %b want 0010", bus.gnt); end
    #2 reset = 1'b1;
    #1;
    n_vec++; if (bus.gnt !== 4'b0000) begin n_err++; $display("FAIL midrst_gnt: got %b want 0000", bus.gnt); end
    n_vec++; if (bus.q !== 8'h00) begin n_err++; $display("FAIL midrst_q: got %h want 00", bus.q); end
    n_vec++; if (bus.q_valid !== 1'b0) begin n_err++; $display("FAIL midrst_valid: got %b want 0", bus.q_valid); end
    n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy: got %b want 0", bus.busy); end
  endtask

  task automatic test_single_owner();
    apply_reset();
    bus.req = 4'b0100;
    tick();  // edge 1
    n_vec++; if (bus.gnt !== 4'b0100 || bus.owner_id !== 2'd2 || bus.busy !== 1'b1) begin
      n_err++; $display("FAIL single_grant: got gnt=%b owner=%0d busy=%b want 0100 2 1", bus.gnt, bus.owner_id, bus.busy);
    end
    tick();  // edge 2
    bus.wr_en = 4'b0100;
    bus.wdata[23:16] = 8'h3C;
    tick();  // edge 3
    n_vec++; if (bus.q !== 8'h3C || bus.q_valid !== 1'b1) begin
      n_err++; $display("FAIL single_write: got q=%h valid=%b want 3c 1", bus.q, bus.q_valid);
    end
    bus.wr_en = '0;
    tick();  // edge 4
    n_vec++; if (bus.gnt !== 4'b0100) begin n_err++; $display("FAIL single_hold: got %b want 0100", bus.gnt); end
    // Write in the same cycle the request drops still lands.
    bus.req   = 4'b0000;
    bus.wr_en = 4'b0100;
    bus.wdata[23:16] = 8'h5A;
    tick();  // edge 5
    n_vec++; if (bus.gnt !== 4'b0000 || bus.busy !== 1'b0 || bus.owner_id !== 2'd0) begin
      n_err++; $display("FAIL single_release: got gnt=%b busy=%b owner=%0d want 0000 0 0", bus.gnt, bus.busy, bus.owner_id);
    end
    n_vec++; if (bus.q !== 8'h5A) begin n_err++; $display("FAIL write_on_drop: got %h want 5a", bus.q); end
    bus.wr_en = '0;
  endtask

  task automatic test_round_robin();
    int unsigned order[5];
    logic [3:0]  mask;
    logic [3:0]  exp_gnt;
`ifdef SHARED_REG_ARB_PRIO0_EN
    mask = 4'b1110;
    order = '{1, 2, 3, 1, 2};
`else
    mask = 4'b1111;
    order = '{0, 1, 2, 3, 0};
`endif
    apply_reset();
    bus.req = mask;
    for (int i = 0; i < 5; i++) begin
      exp_gnt = 4'(1 << order[i]);
      tick();
      n_vec++; if (bus.gnt !== exp_gnt || bus.owner_id !== 2'(order[i])) begin
        n_err++; $display("FAIL rr_grant%0d: got gnt=%b owner=%0d want %b %0d", i, bus.gnt, bus.owner_id, exp_gnt, order[i]);
      end
      bus.req = mask & ~exp_gnt;
      tick();
      n_vec++; if (bus.gnt !== 4'b0000) begin n_err++; $display("FAIL rr_idle%0d: got %b want 0000", i, bus.gnt); end
      bus.req = mask;
    end
    bus.req = '0;
  endtask

  task automatic test_preempt();
    logic [3:0] hmask;
    int         cnt;
    hmask = 4'(1 << Holder);
    apply_reset();
    bus.req = hmask;
    tick();
    n_vec++; if (bus.gnt !== hmask) begin n_err++; $display("FAIL pre_grant: got %b want %b", bus.gnt, hmask); end
    cnt = 1;
    tick();
    if (bus.gnt === hmask) cnt++;
    bus.req = hmask | 4'b1000;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.gnt !== hmask) break;
      cnt++;
    end
    n_vec++; if (cnt != MaxHold) begin n_err++; $display("FAIL pre_hold_len: got %0d cycles want %0d", cnt, MaxHold); end
    n_vec++; if (bus.gnt !== 4'b0000) begin n_err++; $display("FAIL pre_dead_cycle: got %b want 0000", bus.gnt); end
    tick();
    n_vec++; if (bus.gnt !== 4'b1000) begin n_err++; $display("FAIL pre_handover: got %b want 1000", bus.gnt); end
    bus.req = hmask;
    tick();
    n_vec++; if (bus.gnt !== 4'b0000) begin n_err++; $display("FAIL pre_release3: got %b want 0000", bus.gnt); end
    tick();
    n_vec++; if (bus.gnt !== hmask) begin n_err++; $display("FAIL pre_return: got %b want %b", bus.gnt, hmask); end
    bus.req = '0;
  endtask

  task automatic test_hold_no_competitor();
    logic [3:0] hmask;
    hmask = 4'(1 << Holder);
    apply_reset();
    bus.req = hmask;
    repeat (12) tick();
    n_vec++; if (bus.gnt !== hmask) begin n_err++; $display("FAIL hold_alone: got %b want %b", bus.gnt, hmask); end
    // Hold counter is already saturated, so a new competitor forces release at the next edge.
    bus.req = hmask | 4'b0100;
    tick();
    n_vec++; if (bus.gnt !== 4'b0000) begin n_err++; $display("FAIL hold_sat_preempt: got %b want 0000", bus.gnt); end
    tick();
    n_vec++; if (bus.gnt !== 4'b0100) begin n_err++; $display("FAIL hold_next_owner: got %b want 0100", bus.gnt); end
    bus.req = '0;
  endtask

  task automatic test_non_owner_write();
    apply_reset();
    bus.req   = 4'b0010;
    tick();
    bus.wr_en = 4'b0010;
    bus.wdata[15:8] = 8'h11;
    tick();
    n_vec++; if (bus.q !== 8'h11) begin n_err++; $display("FAIL owner_write: got %h want 11", bus.q); end
    bus.wr_en = 4'b0100;
    bus.wdata[23:16] = 8'hFF;
    tick();
    n_vec++; if (bus.q !== 8'h11) begin n_err++; $display("FAIL nonowner_write: got %h want 11", bus.q); end
    bus.wr_en = '0;
    bus.req   = '0;
    tick();
    bus.wr_en = 4'b0010;
    bus.wdata[15:8] = 8'h22;
    tick();
    n_vec++; if (bus.q !== 8'h11 || bus.busy !== 1'b0) begin
      n_err++; $display("FAIL idle_write: got q=%h busy=%b want 11 0", bus.q, bus.busy);
    end
    idle_inputs();
  endtask

  task automatic test_prio0_option();
    apply_reset();
    bus.req = 4'b0001;
    tick();
    bus.req = 4'b0000;
    tick();  // release of owner 0 leaves ptr at 1
    bus.req = 4'b0011;
    tick();
`ifdef SHARED_REG_ARB_PRIO0_EN
    n_vec++; if (bus.gnt !== 4'b0001 || bus.owner_id !== 2'd0) begin
      n_err++; $display("FAIL prio_select: got gnt=%b owner=%0d want 0001 0", bus.gnt, bus.owner_id);
    end
`else
    n_vec++; if (bus.gnt !== 4'b0010 || bus.owner_id !== 2'd1) begin
      n_err++; $display("FAIL prio_select: got gnt=%b owner=%0d want 0010 1", bus.gnt, bus.owner_id);
    end
`endif
    bus.req = '0;
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_reset_mid_grant();
    test_single_owner();
    test_round_robin();
    test_preempt();
    test_hold_no_competitor();
    test_non_owner_write();
    test_prio0_option();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/shared_reg_arbiter.md
Name: shared_reg_arbiter

Overview:
- Round-robin arbiter that shares one DATA_W-bit register between NUM_REQ requesters.
- Requesters request ownership with req/gnt and write through a per-requester wr_en/wdata lane. Only the current owner's writes reach the register.
- A hold counter bounds ownership so that no requester can starve the others.
- Sits in front of any shared configuration or data register in the datapath.

Parameters:
- NUM_REQ, 4, number of requesters (2..16)
- DATA_W, 8, width of the shared register and of each wdata lane
- MAX_HOLD, 8, maximum consecutive grant cycles before forced release when another request is pending (>=1)

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- req  in  NUM_REQ  ownership request; bit i belongs to requester i; level, held while ownership is wanted
- wr_en  in  NUM_REQ  write strobe per requester
- wdata  in  NUM_REQ*DATA_W  write data; lane i = bits [i*DATA_W +: DATA_W]
- gnt  out  NUM_REQ  registered one-hot grant (all zero when idle)
- q  out  DATA_W  shared register contents
- q_valid  out  1  sticky; set on first accepted write
- owner_id  out  $clog2(NUM_REQ)  index of current owner; 0 when idle
- busy  out  1  high while in GRANT state

Behaviour:
- Reset is asynchronous and active-high. While reset is high: gnt=0, q=0, q_valid=0, owner_id=0, busy=0, state=IDLE, ptr=0, hold_cnt=0. This holds at any time, including mid-grant. Operation resumes on the first rising edge after reset deasserts.
- States: IDLE, GRANT.
- IDLE:
  - If any req bit is high at the edge, the winner is the first set bit scanning upward from ptr, wrapping from NUM_REQ-1 to 0.
  - Next state is GRANT; gnt[winner]=1, owner_id=winner, busy=1, hold_cnt=1.
  - If no req bit is high, stay in IDLE.
  - Latency: req sampled at edge k gives gnt high after edge k.
- GRANT, release: if req[owner]=0 at an edge, go to IDLE, gnt=0, ptr=owner+1 mod NUM_REQ.
- GRANT, preempt: if hold_cnt==MAX_HOLD and any other req bit is high at an edge, go to IDLE, gnt=0, ptr=owner+1 mod NUM_REQ. The preempted owner may keep req high and competes normally.
- GRANT, continue: otherwise stay in GRANT; hold_cnt increments and saturates at MAX_HOLD. With no competitor present, the owner may hold the register indefinitely.
- Dead cycle: after any release or preempt, IDLE lasts at least one cycle. gnt is never handed directly owner-to-owner.
- Write acceptance:
  - At an edge where gnt[i]=1 and wr_en[i]=1, q <= wdata lane i and q_valid <= 1.
  - A write in the same cycle that req[i] drops is accepted, because gnt was high during that cycle.
  - wr_en from non-owners, or any wr_en in IDLE, is ignored; q holds.
- Simultaneous requests: resolved only through ptr; no fixed priority (unless the optional feature is enabled).
- Outputs gnt, owner_id and busy are registered; gnt is never combinational from req.
- Invariants:
  - popcount(gnt) <= 1.
  - busy == (gnt != 0).
  - owner_id equals the index of the set gnt bit whenever busy is high.

Optional Feature:
- Macro SHARED_REG_ARB_PRIO0_EN.
- Defined: requester 0 has absolute priority. In IDLE, if req[0]=1 then requester 0 wins regardless of ptr, and requester 0 is never preempted by hold_cnt. Other requesters are still round-robin among themselves and are preempted normally; a pending req[0] counts as a competitor for preemption.
- Undefined: pure round-robin as described above; all requesters are equal.

Test Plan:
- Reset mid-grant:
  - Stimulus: req=4'b0010, wr_en[1]=1, wdata lane1=8'hA5 for 3 cycles; then assert reset asynchronously between edges.
  - Response: q=8'hA5 and q_valid=1 before reset; on reset, gnt, q, q_valid and busy drop to 0 immediately, without waiting for an edge.
- Single owner write/release:
  - Stimulus: req[2]=1 at edge 1; wr_en[2]=1 with data 8'h3C at edge 3; req[2]=0 at edge 5.
  - Response: gnt=4'b0100 from edge 1 to edge 5; q=8'h3C after edge 3; gnt=0 after edge 5.
- Round-robin fairness:
  - Stimulus: req=4'b1111 constant; each owner drops req for 1 cycle immediately after being granted 1 cycle.
  - Response: grant order 0,1,2,3,0, with exactly one IDLE cycle between consecutive grants.
- Preemption:
  - Stimulus: req[0]=1 held; req[3] raised 2 cycles after gnt[0]; MAX_HOLD=8.
  - Response: gnt[0] high exactly 8 cycles, then 1 IDLE cycle, then gnt=4'b1000; gnt[0] returns after req[3] drops.
- Non-owner write ignored:
  - Stimulus: owner 1 holds q=8'h11; requester 2 drives wr_en[2]=1 with data 8'hFF.
  - Response: q stays 8'h11.
- Optional feature:
  - Stimulus: with SHARED_REG_ARB_PRIO0_EN defined, ptr=1 and req=4'b0011.
  - Response: gnt=4'b0001. Without the macro, the same stimulus gives gnt=4'b0010.
